// File: rtl/ctrl_pkg.sv
// Shared controller definitions: instruction field positions, NOP encoding,
// writeback FSM states and small opcode decode helpers.
package ctrl_pkg;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int OPC_MSB  = 27;
    localparam int OPC_LSB  = 21;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 12;

    localparam logic [3:0]  NOP_COND  = 4'b1111;
    localparam logic [31:0] NOP_INSTR = 32'hF000_0000;
    localparam logic [3:0]  CMP_OPC   = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE
    } wb_state_t;

    // Loads live in two opcode groups; bit 4 separates LDR from STR.
    function automatic logic is_ldr(input logic [6:0] opc);
        return ((opc[6:5] == 2'b11) || (opc[6:3] == 4'b1000)) && !opc[4];
    endfunction

    function automatic logic is_data(input logic [6:0] opc);
        return !opc[6] && (opc[5:4] != 2'b10) && (opc[3:0] != CMP_OPC);
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Pipeline-side signals of the writeback stage. The forwarding pair is only
// present when WB_FWD_EN is defined.
interface writeback_unit_if;

    logic [31:0] instr_in;
    logic        branch_in;
    logic        branch_ref;
    logic        sel_stall;
    logic [3:0]  rd;
    logic [31:0] instr_output;
    logic        branch_value;
    logic        w_en2;
    logic [3:0]  w_addr2;
    logic        stall_req;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;

    modport slave (
        input  instr_in, branch_in, branch_ref, sel_stall,
        output rd, instr_output, branch_value, w_en2, w_addr2, stall_req,
        output fwd_valid, fwd_addr
    );

    modport master (
        output instr_in, branch_in, branch_ref, sel_stall,
        input  rd, instr_output, branch_value, w_en2, w_addr2, stall_req,
        input  fwd_valid, fwd_addr
    );
`else
    modport slave (
        input  instr_in, branch_in, branch_ref, sel_stall,
        output rd, instr_output, branch_value, w_en2, w_addr2, stall_req
    );

    modport master (
        output instr_in, branch_in, branch_ref, sel_stall,
        input  rd, instr_output, branch_value, w_en2, w_addr2, stall_req
    );
`endif

endinterface

// File: rtl/wb_load_fsm.sv
// Load sequencer for the writeback stage: waits out the data-memory latency
// for a live LDR, requesting a stall meanwhile, then enables the port-2 write.
module wb_load_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_ldr_i,
    input  logic live_i,
    input  logic sel_stall_i,
    output logic in_wait_o,
    output logic w_en2_o,
    output logic stall_req_o
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

    wb_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load_ldr_i) begin
                    if (MEM_LATENCY == 1) begin
                        state_d = WRITE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                // A squashed load abandons the wait without writing.
                if (!live_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = WRITE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (!sel_stall_i) begin
                    if (!load_ldr_i) begin
                        state_d = IDLE;
                    end else if (MEM_LATENCY == 1) begin
                        state_d = WRITE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign in_wait_o   = (state_q == WAIT);
    assign w_en2_o     = (state_q == WRITE) && live_i;
    assign stall_req_o = (state_q == WAIT) && live_i;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: holds the instruction from the memory stage, squashes it on a
// branch-tag mismatch and writes loaded data to Rd. Optional macro: WB_FWD_EN.
module writeback_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  wb
);

    logic [31:0] instr_q, instr_d;
    logic        tag_q, tag_d;
    logic        in_wait;
    logic        load;
    logic        in_live;
    logic        load_ldr;
    logic        live;

    // The register freezes while a load waits so Rd stays stable until its write.
    assign load     = !wb.sel_stall && !in_wait;
    assign in_live  = (wb.instr_in[COND_MSB:COND_LSB] != NOP_COND) &&
                      (wb.branch_in == wb.branch_ref);
    assign load_ldr = load && in_live && is_ldr(wb.instr_in[OPC_MSB:OPC_LSB]);
    assign live     = (instr_q[COND_MSB:COND_LSB] != NOP_COND) &&
                      (tag_q == wb.branch_ref);

    always_comb begin
        instr_d = instr_q;
        tag_d   = tag_q;
        if (load) begin
            instr_d = wb.instr_in;
            tag_d   = wb.branch_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            tag_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            tag_q   <= tag_d;
        end
    end

    wb_load_fsm #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_load_fsm (
        .clk         (clk),
        .rst         (rst),
        .load_ldr_i  (load_ldr),
        .live_i      (live),
        .sel_stall_i (wb.sel_stall),
        .in_wait_o   (in_wait),
        .w_en2_o     (wb.w_en2),
        .stall_req_o (wb.stall_req)
    );

    assign wb.rd           = instr_q[RD_MSB:RD_LSB];
    assign wb.w_addr2      = instr_q[RD_MSB:RD_LSB];
    assign wb.instr_output = instr_q;
    assign wb.branch_value = tag_q;

`ifdef WB_FWD_EN
    // A live load forwards only during its write cycle, which w_en2 already marks.
    assign wb.fwd_valid = wb.w_en2 || (live && is_data(instr_q[OPC_MSB:OPC_LSB]));
    assign wb.fwd_addr  = instr_q[RD_MSB:RD_LSB];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: two instances (MEM_LATENCY 1 and 3)
// share one stimulus stream and are compared each cycle against a behavioural model.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instrIn;
    logic        branchIn;
    logic        branchRef;
    logic        selStall;

    int nChecks = 0;
    int nFails  = 0;

    writeback_unit_if wbIf1 ();
    writeback_unit_if wbIf3 ();

    assign wbIf1.instr_in   = instrIn;
    assign wbIf1.branch_in  = branchIn;
    assign wbIf1.branch_ref = branchRef;
    assign wbIf1.sel_stall  = selStall;
    assign wbIf3.instr_in   = instrIn;
    assign wbIf3.branch_in  = branchIn;
    assign wbIf3.branch_ref = branchRef;
    assign wbIf3.sel_stall  = selStall;

    writeback_unit #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .wb(wbIf1));
    writeback_unit #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .wb(wbIf3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'hF000_0000;

    function automatic logic [31:0] mkInstr(input logic [3:0] cond, input logic [6:0] opc,
                                            input logic [3:0] rdF);
        return {cond, opc, 5'b00000, rdF, 12'h000};
    endfunction

    function automatic logic [31:0] ldr(input logic [3:0] rdF);
        return mkInstr(4'hE, 7'b1100000, rdF);
    endfunction

    // Behavioural model: what a stage with a given memory latency must show.
    typedef struct {
        logic [31:0] instr;
        logic        tag;
        int          stallLeft;
        bit          writing;
    } mstate_t;

    mstate_t mS [2];

    function automatic bit isLdrOp(input logic [31:0] i);
        logic [6:0] op;
        op = i[27:21];
        return ((op[6:5] == 2'b11) || (op[6:3] == 4'b1000)) && (op[4] == 1'b0);
    endfunction

    function automatic bit isDataOp(input logic [31:0] i);
        logic [6:0] op;
        op = i[27:21];
        return (op[6] == 1'b0) && (op[5:4] != 2'b10) && (op[3:0] != 4'b1010);
    endfunction

    function automatic bit isLive(input logic [31:0] i, input logic tag, input logic brRef);
        return (i[31:28] != 4'hF) && (tag == brRef);
    endfunction

    function automatic int latencyOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic mstate_t modelStep(input mstate_t s, input int lat, input logic [31:0] iIn,
                                          input logic bIn, input logic bRef, input logic stl);
        mstate_t n;
        n = s;
        if (s.stallLeft > 0) begin
            if (!isLive(s.instr, s.tag, bRef)) begin
                n.stallLeft = 0;
                n.writing   = 0;
            end else begin
                n.stallLeft = s.stallLeft - 1;
                n.writing   = (n.stallLeft == 0);
            end
        end else if (!stl) begin
            n.instr = iIn;
            n.tag   = bIn;
            if (isLdrOp(iIn) && isLive(iIn, bIn, bRef)) begin
                n.stallLeft = lat - 1;
                n.writing   = (lat == 1);
            end else begin
                n.stallLeft = 0;
                n.writing   = 0;
            end
        end
        return n;
    endfunction

    function automatic mstate_t modelReset();
        mstate_t n;
        n.instr     = NOP;
        n.tag       = 1'b0;
        n.stallLeft = 0;
        n.writing   = 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mS[0] <= modelReset();
            mS[1] <= modelReset();
        end else begin
            mS[0] <= modelStep(mS[0], latencyOf(0), instrIn, branchIn, branchRef, selStall);
            mS[1] <= modelStep(mS[1], latencyOf(1), instrIn, branchIn, branchRef, selStall);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input string tag, input mstate_t s, input logic [31:0] instrOut,
                              input logic [3:0] rdO, input logic [3:0] waddr, input logic bv,
                              input logic wen, input logic stall);
        bit live;
        live = isLive(s.instr, s.tag, branchRef);
        checkOutput({tag, " instr_output"}, instrOut, s.instr);
        checkOutput({tag, " rd"}, 32'(rdO), 32'(s.instr[15:12]));
        checkOutput({tag, " w_addr2"}, 32'(waddr), 32'(s.instr[15:12]));
        checkOutput({tag, " branch_value"}, 32'(bv), 32'(s.tag));
        checkOutput({tag, " w_en2"}, 32'(wen), 32'(s.writing && live));
        checkOutput({tag, " stall_req"}, 32'(stall), 32'((s.stallLeft > 0) && live));
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            compareDut("ml1", mS[0], wbIf1.instr_output, wbIf1.rd, wbIf1.w_addr2,
                       wbIf1.branch_value, wbIf1.w_en2, wbIf1.stall_req);
            compareDut("ml3", mS[1], wbIf3.instr_output, wbIf3.rd, wbIf3.w_addr2,
                       wbIf3.branch_value, wbIf3.w_en2, wbIf3.stall_req);
`ifdef WB_FWD_EN
            checkOutput("ml1 fwd_valid", 32'(wbIf1.fwd_valid),
                        32'(isLive(mS[0].instr, mS[0].tag, branchRef) &&
                            (mS[0].writing || isDataOp(mS[0].instr))));
            checkOutput("ml1 fwd_addr", 32'(wbIf1.fwd_addr), 32'(mS[0].instr[15:12]));
`endif
        end
    end

    task automatic applyStimulus(input logic [31:0] instr, input logic bIn, input logic bRef,
                                 input logic stl);
        instrIn   = instr;
        branchIn  = bIn;
        branchRef = bRef;
        selStall  = stl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        instrIn   = NOP;
        branchIn  = 1'b0;
        branchRef = 1'b0;
        selStall  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset instr_output", wbIf1.instr_output, 32'hF000_0000);
        checkOutput("reset rd", 32'(wbIf1.rd), 32'd0);
        checkOutput("reset w_en2", 32'(wbIf3.w_en2), 32'd0);
        checkOutput("reset stall_req", 32'(wbIf3.stall_req), 32'd0);
        checkOutput("reset branch_value", 32'(wbIf1.branch_value), 32'd0);
        rst = 1'b0;
        applyStimulus(NOP, 0, 0, 0);

        // LDR rd=7: single-cycle write on ML=1, two stall cycles then write on ML=3.
        applyStimulus(ldr(4'd7), 0, 0, 0);
        checkOutput("ml1 ldr w_en2", 32'(wbIf1.w_en2), 32'd1);
        checkOutput("ml1 ldr w_addr2", 32'(wbIf1.w_addr2), 32'd7);
        checkOutput("ml1 ldr stall_req", 32'(wbIf1.stall_req), 32'd0);
        checkOutput("ml3 ldr stall c1", 32'(wbIf3.stall_req), 32'd1);
        applyStimulus(NOP, 0, 0, 0);
        checkOutput("ml1 ldr w_en2 off", 32'(wbIf1.w_en2), 32'd0);
        checkOutput("ml3 ldr stall c2", 32'(wbIf3.stall_req), 32'd1);
        checkOutput("ml3 ldr held", wbIf3.instr_output, ldr(4'd7));
        applyStimulus(NOP, 0, 0, 0);
        checkOutput("ml3 ldr stall c3", 32'(wbIf3.stall_req), 32'd0);
        checkOutput("ml3 ldr w_en2", 32'(wbIf3.w_en2), 32'd1);
        checkOutput("ml3 ldr w_addr2", 32'(wbIf3.w_addr2), 32'd7);
        applyStimulus(NOP, 0, 0, 0);
        checkOutput("ml3 ldr w_en2 off", 32'(wbIf3.w_en2), 32'd0);

        // Back-to-back loads on ML=1 write on consecutive cycles.
        applyStimulus(ldr(4'd1), 0, 0, 0);
        checkOutput("b2b first addr", 32'(wbIf1.w_addr2), 32'd1);
        applyStimulus(mkInstr(4'hE, 7'b1000000, 4'd2), 0, 0, 0);
        checkOutput("b2b second w_en2", 32'(wbIf1.w_en2), 32'd1);
        checkOutput("b2b second addr", 32'(wbIf1.w_addr2), 32'd2);
        repeat (3) applyStimulus(NOP, 0, 0, 0);

        // Squash at capture: tag does not match the reference.
        applyStimulus(ldr(4'd5), 0, 1, 0);
        checkOutput("squash w_en2", 32'(wbIf1.w_en2), 32'd0);
        checkOutput("squash stall_req", 32'(wbIf3.stall_req), 32'd0);
        applyStimulus(NOP, 0, 0, 0);

        // Branch reference flips mid-wait: stall drops at once and no write follows.
        applyStimulus(ldr(4'd9), 0, 0, 0);
        checkOutput("midwait stall before", 32'(wbIf3.stall_req), 32'd1);
        branchRef = 1'b1;
        #1;
        checkOutput("midwait stall dropped", 32'(wbIf3.stall_req), 32'd0);
        applyStimulus(NOP, 0, 1, 0);
        checkOutput("midwait no write c1", 32'(wbIf3.w_en2), 32'd0);
        applyStimulus(NOP, 0, 1, 0);
        checkOutput("midwait no write c2", 32'(wbIf3.w_en2), 32'd0);
        applyStimulus(NOP, 0, 0, 0);

        // Stall hold then release.
        applyStimulus(mkInstr(4'hE, 7'b0000100, 4'd3), 0, 0, 0);
`ifdef WB_FWD_EN
        checkOutput("fwd add valid", 32'(wbIf1.fwd_valid), 32'd1);
        checkOutput("fwd add addr", 32'(wbIf1.fwd_addr), 32'd3);
`endif
        applyStimulus(mkInstr(4'hE, 7'b1110000, 4'd6), 0, 0, 1);
        checkOutput("stall hold", wbIf1.instr_output, mkInstr(4'hE, 7'b0000100, 4'd3));
        applyStimulus(mkInstr(4'hE, 7'b1110000, 4'd6), 0, 0, 0);
        checkOutput("stall release", wbIf1.instr_output, mkInstr(4'hE, 7'b1110000, 4'd6));
        checkOutput("str no write", 32'(wbIf1.w_en2), 32'd0);
`ifdef WB_FWD_EN
        checkOutput("fwd str valid", 32'(wbIf1.fwd_valid), 32'd0);
        applyStimulus(mkInstr(4'hE, 7'b0001010, 4'd4), 0, 0, 0);
        checkOutput("fwd cmp valid", 32'(wbIf1.fwd_valid), 32'd0);
`endif

        // Asynchronous reset in the middle of a wait aborts the load.
        applyStimulus(ldr(4'd4), 0, 0, 0);
        checkOutput("rstwait stall before", 32'(wbIf3.stall_req), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstwait instr_output", wbIf3.instr_output, 32'hF000_0000);
        checkOutput("rstwait stall_req", 32'(wbIf3.stall_req), 32'd0);
        checkOutput("rstwait rd", 32'(wbIf3.rd), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NOP, 0, 0, 0);
            checkOutput("rstwait no write", 32'(wbIf3.w_en2), 32'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
